// File: rtl/io_pkg.sv
// Shared definitions for the memory-mapped IO bridge devices.
package io_pkg;

  // Register word indices of the switch input device (bridge supplies Addr[3:2]).
  localparam logic [1:0] SW_REG_STATE = 2'd0;
  localparam logic [1:0] SW_REG_EDGE  = 2'd1;
  localparam logic [1:0] SW_REG_MASK  = 2'd2;
  localparam logic [1:0] SW_REG_RSVD  = 2'd3;

  // Depth of the tick-sample history used to qualify a level change.
  localparam int SW_SAMPLES = 3;

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: 2-flop synchronizer, active-low to pressed=1 inversion,
// 3-deep tick-sampled history and the debounced level flop.
module debounce_bit
  import io_pkg::*;
(
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_tick,
  input  logic i_pin_n,
  output logic o_stable,
  output logic o_rise
);

  logic                  r_sync1;
  logic                  r_sync2;
  logic [SW_SAMPLES-1:0] r_samp;
  logic                  r_stable;

  logic w_pressed;
  logic w_all_one;
  logic w_all_zero;
  logic w_stable_nxt;

  assign w_pressed  = ~r_sync2;
  assign w_all_one  = &r_samp;
  assign w_all_zero = ~|r_samp;

  // Level only moves when the whole history agrees; disagreement holds it.
  assign w_stable_nxt = w_all_one  ? 1'b1 :
                        w_all_zero ? 1'b0 : r_stable;

  // Rising edge of the debounced level, visible in the cycle it will be
  // registered so the edge flag sets together with the level.
  assign o_rise   = w_stable_nxt & ~r_stable;
  assign o_stable = r_stable;

  // Synchronizer resets to the released (high) pin level.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_pin_n;
      r_sync2 <= r_sync1;
    end
  end

  // Sample history shifts only on the shared tick.
  always_ff @(posedge i_clk) begin
    if (i_reset)     r_samp <= '0;
    else if (i_tick) r_samp <= {r_samp[SW_SAMPLES-2:0], w_pressed};
  end

  // Debounced level.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_stable <= 1'b0;
    else         r_stable <= w_stable_nxt;
  end

endmodule

// File: rtl/switch_driver.sv
// Memory-mapped switch/button input device: debounced level (STATE),
// sticky press flags (EDGE, write-1-to-clear), interrupt mask (MASK) and
// a registered level IRQ. Reads are combinational from Addr.
module switch_driver
  import io_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             WE,
  input  logic [1:0]       Addr,
  input  logic [31:0]      Din,
  output logic [31:0]      Dout,
  input  logic [WIDTH-1:0] switch_pin,
  output logic             IRQ
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_edge;
  logic [WIDTH-1:0] r_mask;
  logic             r_irq;

  logic             w_tick;
  logic [WIDTH-1:0] w_stable;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_din;
  logic [WIDTH-1:0] w_clr;
  logic             w_we_edge;
  logic             w_we_mask;

  assign w_tick    = (r_cnt == CNT_LAST);
  assign w_din     = Din[WIDTH-1:0];
  assign w_we_edge = WE && (Addr == SW_REG_EDGE);
  assign w_we_mask = WE && (Addr == SW_REG_MASK);
  assign w_clr     = w_we_edge ? w_din : '0;

  // Upper write-data bits have no storage behind them.
  if (WIDTH < 32) begin : g_unused
    logic w_unused_din;
    assign w_unused_din = ^Din[31:WIDTH];
  end

  // Free-running sample-tick counter, 0..DEBOUNCE_CYCLES-1.
  always_ff @(posedge clk) begin
    if (reset)       r_cnt <= '0;
    else if (w_tick) r_cnt <= '0;
    else             r_cnt <= r_cnt + CW'(1);
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    debounce_bit u_db (
      .i_clk    (clk),
      .i_reset  (reset),
      .i_tick   (w_tick),
      .i_pin_n  (switch_pin[g]),
      .o_stable (w_stable[g]),
      .o_rise   (w_rise[g])
    );
  end

  // Sticky press flags; a new press beats a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) r_edge <= '0;
    else       r_edge <= (r_edge & ~w_clr) | w_rise;
  end

  // Interrupt enable register.
  always_ff @(posedge clk) begin
    if (reset)          r_mask <= '0;
    else if (w_we_mask) r_mask <= w_din;
  end

  // IRQ follows last cycle's pending-and-enabled flags.
  always_ff @(posedge clk) begin
    if (reset) r_irq <= 1'b0;
    else       r_irq <= |(r_edge & r_mask);
  end

  assign IRQ = r_irq;

  // Read mux; unimplemented bits and the reserved slot read zero.
  always_comb begin
    Dout = '0;
    case (Addr)
      SW_REG_STATE: Dout[WIDTH-1:0] = w_stable;
      SW_REG_EDGE:  Dout[WIDTH-1:0] = r_edge;
      SW_REG_MASK:  Dout[WIDTH-1:0] = r_mask;
      default:      Dout = '0;
    endcase
  end

endmodule

// File: tb/tb_switch_driver.sv
// Scoreboard bench for switch_driver (WIDTH=8, DEBOUNCE_CYCLES=4).
module tb_switch_driver;
  import io_pkg::*;

  localparam int W = 8;
  localparam int D = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          WE;
  logic [1:0]    Addr;
  logic [31:0]   Din;
  logic [31:0]   Dout;
  logic [W-1:0]  switch_pin;
  logic          IRQ;

  always #5 clk = ~clk;

  switch_driver #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .reset      (reset),
    .WE         (WE),
    .Addr       (Addr),
    .Din        (Din),
    .Dout       (Dout),
    .switch_pin (switch_pin),
    .IRQ        (IRQ)
  );

  typedef struct {
    logic [31:0] dout;
    logic        irq;
    logic [1:0]  a;
    bit          cst;
    bit          tmo;
  } exp_t;

  exp_t sbq[$];
  bit   rd_req = 1'b0;
  int   n_vec  = 0;
  int   n_bad  = 0;

  // Reference model: pressed levels reach the sampler two clocks late,
  // are sampled every D-th clock, and a level is accepted once the last
  // three samples agree.
  int           m_cnt;
  logic [W-1:0] m_dly[$];
  logic [W-1:0] m_smp[3];
  logic [W-1:0] m_stable, m_edge, m_mask;
  logic         m_irq;

  function automatic logic [31:0] m_read(input logic [1:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      SW_REG_STATE: r[W-1:0] = m_stable;
      SW_REG_EDGE:  r[W-1:0] = m_edge;
      SW_REG_MASK:  r[W-1:0] = m_mask;
      default:      r = '0;
    endcase
    return r;
  endfunction

  task automatic model_step();
    logic [W-1:0] n_st, n_edge, clr, syn;
    logic         n_irq;
    if (reset) begin
      m_cnt = 0;
      m_dly.delete();
      m_dly.push_back('0);
      m_dly.push_back('0);
      m_smp[0] = '0; m_smp[1] = '0; m_smp[2] = '0;
      m_stable = '0; m_edge = '0; m_mask = '0; m_irq = 1'b0;
    end else begin
      n_irq = |(m_edge & m_mask);
      n_st  = m_stable;
      for (int i = 0; i < W; i++)
        if (m_smp[0][i] == m_smp[1][i] && m_smp[1][i] == m_smp[2][i])
          n_st[i] = m_smp[0][i];
      clr    = (WE && Addr == SW_REG_EDGE) ? Din[W-1:0] : '0;
      n_edge = (m_edge & ~clr) | (n_st & ~m_stable);
      if (WE && Addr == SW_REG_MASK) m_mask = Din[W-1:0];
      syn = m_dly.pop_front();
      m_dly.push_back(~switch_pin);
      if (m_cnt == D - 1) begin
        m_smp[2] = m_smp[1];
        m_smp[1] = m_smp[0];
        m_smp[0] = syn;
      end
      m_cnt    = (m_cnt + 1) % D;
      m_stable = n_st;
      m_edge   = n_edge;
      m_irq    = n_irq;
    end
  endtask

  // Advance one clock; called at posedge+1 with inputs already driven.
  task automatic step();
    rd_req = 1'b1;
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Read (and optionally write) with the expectation taken from the model.
  task automatic cyc(input logic we, input logic [1:0] a, input logic [31:0] d);
    exp_t e;
    WE = we; Addr = a; Din = d;
    e.dout = m_read(a); e.irq = m_irq; e.a = a; e.cst = 1'b0; e.tmo = 1'b0;
    sbq.push_back(e);
    step();
  endtask

  // Read with a fixed expectation derived by hand from the scenario.
  task automatic chk(input logic [1:0] a, input logic [31:0] ed, input logic ei);
    exp_t e;
    WE = 1'b0; Addr = a; Din = '0;
    e.dout = ed; e.irq = ei; e.a = a; e.cst = 1'b1; e.tmo = 1'b0;
    sbq.push_back(e);
    step();
  endtask

  task automatic timeout();
    exp_t e;
    WE = 1'b0; Addr = SW_REG_STATE; Din = '0;
    e.dout = '0; e.irq = 1'b0; e.a = SW_REG_STATE; e.cst = 1'b0; e.tmo = 1'b1;
    sbq.push_back(e);
    step();
  endtask

  // Monitor: every presented read is popped and compared.
  always @(negedge clk) begin
    exp_t e;
    if (rd_req) begin
      if (sbq.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL sb_empty: read presented with no expectation queued");
      end else begin
        e = sbq.pop_front();
        if (e.tmo) begin
          n_vec++; n_bad++;
          $display("FAIL wait_bound: awaited condition not reached within cycle budget");
        end else begin
          n_vec += 2;
          if (Dout !== e.dout) begin
            n_bad++;
            $display("FAIL %s_dout addr=%0d got=%h want=%h t=%0t",
                     e.cst ? "chk" : "model", e.a, Dout, e.dout, $time);
          end
          if (IRQ !== e.irq) begin
            n_bad++;
            $display("FAIL %s_irq addr=%0d got=%b want=%b t=%0t",
                     e.cst ? "chk" : "model", e.a, IRQ, e.irq, $time);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    reset = 1'b1; WE = 1'b0; Addr = '0; Din = '0; switch_pin = '1;
    @(posedge clk);
    model_step();
    #1;
    cyc(1'b0, SW_REG_STATE, '0);
    reset = 1'b0;
    chk(SW_REG_STATE, 32'h0, 1'b0);
    chk(SW_REG_EDGE,  32'h0, 1'b0);
    chk(SW_REG_MASK,  32'h0, 1'b0);
    chk(SW_REG_RSVD,  32'h0, 1'b0);

    // Clean press of bit 0: settles within 3*D+3 clocks.
    switch_pin = 8'hFE;
    for (int i = 0; i < 15; i++) cyc(1'b0, SW_REG_STATE, '0);
    chk(SW_REG_STATE, 32'h1, 1'b0);
    chk(SW_REG_EDGE,  32'h1, 1'b0);

    // Interrupt flow.
    cyc(1'b1, SW_REG_MASK, 32'h1);
    chk(SW_REG_MASK,  32'h1, 1'b0);
    chk(SW_REG_EDGE,  32'h1, 1'b1);
    cyc(1'b1, SW_REG_EDGE, 32'h1);
    chk(SW_REG_EDGE,  32'h0, 1'b1);
    chk(SW_REG_STATE, 32'h1, 1'b0);

    // Bounce on bit 1: 3-clock pulses never span two ticks.
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) switch_pin[1] = ~switch_pin[1];
      cyc(1'b0, SW_REG_STATE, '0);
    end
    switch_pin[1] = 1'b1;
    for (int i = 0; i < 16; i++) cyc(1'b0, SW_REG_STATE, '0);
    chk(SW_REG_STATE, 32'h1, 1'b0);
    chk(SW_REG_EDGE,  32'h0, 1'b0);

    // Collision: clear bit 2 in the very cycle it is set.
    switch_pin[2] = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_smp[0][2] && m_smp[1][2] && m_smp[2][2] && !m_stable[2]) begin
        cyc(1'b1, SW_REG_EDGE, 32'h4);
        found = 1'b1;
      end else begin
        cyc(1'b0, SW_REG_EDGE, '0);
      end
    end
    if (!found) timeout();
    chk(SW_REG_EDGE,  32'h4, 1'b0);
    chk(SW_REG_STATE, 32'h5, 1'b0);

    // Writes to read-only and reserved slots.
    cyc(1'b1, SW_REG_RSVD, 32'hFFFF_FFFF);
    chk(SW_REG_RSVD,  32'h0, 1'b0);
    cyc(1'b1, SW_REG_STATE, 32'hFFFF_FFFF);
    chk(SW_REG_STATE, 32'h5, 1'b0);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      logic        we;
      logic [1:0]  a;
      logic [31:0] d;
      if ($urandom_range(0, 11) == 0) switch_pin = W'($urandom);
      we = ($urandom_range(0, 5) == 0);
      a  = 2'($urandom_range(0, 3));
      d  = $urandom;
      cyc(we, a, d);
    end

    // Reset in the middle of a debounce.
    reset = 1'b1; switch_pin = '1;
    cyc(1'b0, SW_REG_STATE, '0);
    cyc(1'b0, SW_REG_STATE, '0);
    reset = 1'b0;
    chk(SW_REG_STATE, 32'h0, 1'b0);
    switch_pin = 8'hF7;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_smp[0][3] && m_smp[1][3] && !m_smp[2][3]) found = 1'b1;
      else cyc(1'b0, SW_REG_STATE, '0);
    end
    if (!found) timeout();
    reset = 1'b1;
    cyc(1'b0, SW_REG_STATE, '0);
    reset = 1'b0;
    for (int j = 0; j < 13; j++) chk(SW_REG_STATE, 32'h0, 1'b0);
    chk(SW_REG_STATE, 32'h8, 1'b0);
    chk(SW_REG_EDGE,  32'h8, 1'b0);

    rd_req = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
